dc_ipu_divider_arbiter: RTL and testbench
=========================================

Name: dc_ipu_divider_arbiter

Overview:
Shares one pipelined array divider (A_WIDTH-stage, valid/ready, global stall on out_ready) between N_REQ requesters, e.g. H/V scale-factor and phase-step calculators in the IPU.
Round-robin arbitration on the divider input. A requester-ID tag FIFO tracks outstanding operations so in-order results are steered back to their owner. It also drives the divider's synchronous clear.

Parameters:
N_REQ, 3, number of requesters (2..8)
A_WIDTH, 16, dividend/quotient width; must match divider
B_WIDTH, 8, divisor/remainder width; must match divider
MAX_OUTSTANDING, 18, max accepted-not-returned ops; must be >= A_WIDTH+2; sets tag FIFO depth

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
clr  in  1  synchronous flush of arbiter and divider; in-flight ops are dropped
req_valid  in  N_REQ  per-requester operand valid
req_ready  out  N_REQ  per-requester operand accepted
req_a  in  N_REQ*A_WIDTH  packed dividends; requester k at [k*A_WIDTH +: A_WIDTH]
req_b  in  N_REQ*B_WIDTH  packed divisors
resp_valid  out  N_REQ  one-hot result valid
resp_ready  in  N_REQ  per-requester result accept
resp_q  out  A_WIDTH  quotient, broadcast to all requesters
resp_r  out  B_WIDTH  remainder, broadcast to all requesters
resp_dz  out  1  divide-by-zero flag (optional feature)
div_clr  out  1  to divider clr
div_in_valid  out  1  to divider in_valid
div_in_ready  in  1  from divider in_ready
div_a  out  A_WIDTH  to divider a
div_b  out  B_WIDTH  to divider b
div_out_valid  in  1  from divider out_valid
div_out_ready  out  1  to divider out_ready (pipeline enable)
div_q  in  A_WIDTH  from divider q
div_r  in  B_WIDTH  from divider r

Behaviour:
- Reset/clr, same cycle: rr_ptr=N_REQ-1, lock=0, FIFO empty, count=0. div_clr = reset | clr (combinational). All req_ready, resp_valid, div_in_valid = 0 while reset|clr is high.
- Arbitration: the candidate is the first req_valid[k] scanning from rr_ptr+1 with wrap-around.
  - div_in_valid = any valid & count<MAX_OUTSTANDING.
  - div_a/div_b are muxed from the granted index.
  - req_ready[g] = div_in_ready & div_in_valid; the other req_ready bits are 0.
- Grant lock: if div_in_valid & !div_in_ready, register lock=1 and the granted index. While locked, the grant is held even if a higher-priority requester raises valid, keeping div_a/div_b stable. Unlock on handshake.
- Handshake (div_in_valid & div_in_ready): push the granted ID into the tag FIFO and set rr_ptr=granted ID.
- Credit: count +1 on handshake, -1 on result return, unchanged when both occur. At count==MAX_OUTSTANDING, div_in_valid=0.
- Return path (FIFO head h):
  - resp_valid[h] = div_out_valid; resp_q=div_q, resp_r=div_r.
  - div_out_ready = resp_ready[h] when FIFO is non-empty.
  - Pop on div_out_valid & div_out_ready.
  - A stalled requester back-pressures the whole divider pipeline. This in-order global stall is intended.
- Throughput: 1 op/cycle when no stall. Arbiter adds 0 cycles of latency each way; end-to-end latency equals divider latency.
- Errors: div_out_valid with FIFO empty is a protocol error. Flag it by assertion, drive div_out_ready=1 to drain, and assert no resp_valid. FIFO overflow cannot occur by construction; assert it anyway.
- Requesters must hold req_valid and operands until req_ready. Results are returned in acceptance order.

Optional Feature:
DC_IPU_DIV_ARB_DZ_FLAG_EN
- Defined: tag FIFO entries are {dz, id}, with dz = (div_b==0) at acceptance. resp_dz = head dz while resp_valid is high, otherwise 0. The divider still runs; q/r are passed through unchanged.
- Undefined: tag holds the ID only; resp_dz is tied to 0.

Decomposition:
- Package dc_ipu_div_arb_pkg:
  - ID_WIDTH function: clog2 with a minimum of 1.
  - Tag struct: id, plus dz under the macro.
  - Round-robin next-index function.
- Sub-module dc_ipu_div_arb_tag_fifo: synchronous FIFO of tags, parameterised depth. Provides push/pop/head/empty/full/count with sync clear; count doubles as the credit counter.

Test Plan:
- Single op, N_REQ=3, A=16, B=8: req 1 sends a=1000, b=7 → resp_valid=3'b010 after divider latency, q=142, r=6; count back to 0.
- All 3 requesters valid continuously with operands k*100+1 / 3 → grants cycle 0,1,2,0,... and each requester receives its own results in order.
- Hold resp_ready[0]=0 for 10 cycles while its result is at FIFO head → div_out_ready=0 and pipeline frozen; results resume intact after release.
- div_in_ready low while req 2 is granted, then req 0 rises → grant stays 2 and div_a/div_b stable until handshake.
- Fill to MAX_OUTSTANDING with all resp_ready=0 → div_in_valid=0 and no req_ready. With handshake and return in the same cycle, count is unchanged.
- Assert clr mid-stream with 5 ops in flight → div_clr high, FIFO empty, no stray resp_valid afterwards. A new op a=255, b=16 returns q=15, r=15. With the macro defined, b=0 gives resp_dz=1.

Source files
------------

// File: rtl/dc_ipu_div_arb_pkg.sv
// dc_ipu_div_arb_pkg: shared types and helpers for the divider arbiter.
//   tag_t    : tag FIFO entry; requester ID, plus a divide-by-zero flag when
//              DC_IPU_DIV_ARB_DZ_FLAG_EN is defined.
//   id_width : requester-index width (clog2, minimum 1).
//   rr_pick  : round-robin scan starting just after the last grant.
package dc_ipu_div_arb_pkg;

    localparam int MAX_REQ  = 8;
    localparam int ID_MAX_W = 3;

    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

`ifdef DC_IPU_DIV_ARB_DZ_FLAG_EN
    typedef struct packed {
        logic                dz;
        logic [ID_MAX_W-1:0] id;
    } tag_t;
`else
    typedef struct packed {
        logic [ID_MAX_W-1:0] id;
    } tag_t;
`endif

    // Scans downwards so the lowest offset from ptr wins; offset n (ptr
    // itself) has the lowest priority. Returns ptr when nothing is valid.
    function automatic logic [ID_MAX_W-1:0] rr_pick(
        input logic [MAX_REQ-1:0]  valid,
        input logic [ID_MAX_W-1:0] ptr,
        input int                  n
    );
        int k;
        rr_pick = ptr;
        for (int i = n; i >= 1; i--) begin
            k = (int'(ptr) + i) % n;
            if (valid[ID_MAX_W'(k)]) rr_pick = ID_MAX_W'(k);
        end
    endfunction

endpackage

// File: rtl/dc_ipu_div_arb_tag_fifo.sv
// dc_ipu_div_arb_tag_fifo: synchronous tag FIFO; its occupancy is the credit count.
//   clk, reset, clr : clock, sync active-high reset, sync flush
//   push, din       : write a tag (ignored when full)
//   pop             : drop the head tag (ignored when empty)
//   head            : tag at the read pointer
//   empty, full     : occupancy flags
//   count           : number of stored tags
module dc_ipu_div_arb_tag_fifo
    import dc_ipu_div_arb_pkg::*;
#(
    parameter int DEPTH = 18,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr,
    input  logic          push,
    input  tag_t          din,
    input  logic          pop,
    output tag_t          head,
    output logic          empty,
    output logic          full,
    output logic [CW-1:0] count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    tag_t          mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    // Depth need not be a power of two, so pointers wrap explicitly.
    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        empty   = (count == '0);
        full    = (count == CW'(DEPTH));
        do_push = push && !full;
        do_pop  = pop && !empty;
        head    = mem[rd_ptr];
    end

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= inc(wr_ptr);
            if (do_pop) rd_ptr <= inc(rd_ptr);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    // The credit limit in the arbiter keeps pushes away from a full FIFO.
    assert property (@(posedge clk) disable iff (reset || clr) !(push && full));

endmodule

// File: rtl/dc_ipu_divider_arbiter.sv
// dc_ipu_divider_arbiter: round-robin sharing of one pipelined divider by N_REQ requesters.
//   clk, reset, clr         : clock, sync active-high reset, sync flush (drops in-flight ops)
//   req_valid/ready/a/b     : per-requester operand handshake, packed operands
//   resp_valid/ready        : one-hot result valid, per-requester accept
//   resp_q, resp_r, resp_dz : broadcast quotient, remainder, divide-by-zero flag
//   div_*                   : divider interface (clr, input handshake, output handshake/stall)
//   Optional DC_IPU_DIV_ARB_DZ_FLAG_EN: carry a divide-by-zero flag with each tag.
module dc_ipu_divider_arbiter
    import dc_ipu_div_arb_pkg::*;
#(
    parameter int N_REQ           = 3,
    parameter int A_WIDTH         = 16,
    parameter int B_WIDTH         = 8,
    parameter int MAX_OUTSTANDING = 18
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       clr,
    input  logic [N_REQ-1:0]           req_valid,
    output logic [N_REQ-1:0]           req_ready,
    input  logic [N_REQ*A_WIDTH-1:0]   req_a,
    input  logic [N_REQ*B_WIDTH-1:0]   req_b,
    output logic [N_REQ-1:0]           resp_valid,
    input  logic [N_REQ-1:0]           resp_ready,
    output logic [A_WIDTH-1:0]         resp_q,
    output logic [B_WIDTH-1:0]         resp_r,
    output logic                       resp_dz,
    output logic                       div_clr,
    output logic                       div_in_valid,
    input  logic                       div_in_ready,
    output logic [A_WIDTH-1:0]         div_a,
    output logic [B_WIDTH-1:0]         div_b,
    input  logic                       div_out_valid,
    output logic                       div_out_ready,
    input  logic [A_WIDTH-1:0]         div_q,
    input  logic [B_WIDTH-1:0]         div_r
);

    localparam int IW = id_width(N_REQ);
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);

    logic          flush;
    logic          lock;
    logic [IW-1:0] lock_id;
    logic [IW-1:0] rr_ptr;
    logic [IW-1:0] cand;
    logic [IW-1:0] grant;
    logic [IW-1:0] head_id;
    logic          hs;
    logic          pop;
    logic          empty;
    logic          full;
    logic [CW-1:0] count;
    tag_t          push_tag;
    tag_t          head_tag;

    always_comb begin
        flush        = reset | clr;
        div_clr      = flush;
        cand         = IW'(rr_pick(MAX_REQ'(req_valid), ID_MAX_W'(rr_ptr), N_REQ));
        // A stalled offer keeps its grant so the divider sees stable operands.
        grant        = lock ? lock_id : cand;
        div_in_valid = !flush && (|req_valid) && (count < CW'(MAX_OUTSTANDING));
        hs           = div_in_valid && div_in_ready;
        req_ready    = hs ? N_REQ'(1) << grant : '0;
        div_a        = req_a[int'(grant)*A_WIDTH +: A_WIDTH];
        div_b        = req_b[int'(grant)*B_WIDTH +: B_WIDTH];
        push_tag     = '0;
        push_tag.id  = ID_MAX_W'(grant);
`ifdef DC_IPU_DIV_ARB_DZ_FLAG_EN
        push_tag.dz  = (div_b == '0);
`endif
        // Results come back in issue order, so the FIFO head owns the output.
        // With nothing outstanding the output is drained rather than stalled.
        head_id       = IW'(head_tag.id);
        div_out_ready = empty ? 1'b1 : resp_ready[head_id];
        resp_valid    = (!flush && !empty && div_out_valid) ? N_REQ'(1) << head_id : '0;
        pop           = div_out_valid && div_out_ready && !empty;
        resp_q        = div_q;
        resp_r        = div_r;
`ifdef DC_IPU_DIV_ARB_DZ_FLAG_EN
        resp_dz       = (|resp_valid) && head_tag.dz;
`else
        resp_dz       = 1'b0;
`endif
    end

    always_ff @(posedge clk) begin
        if (flush) begin
            rr_ptr  <= IW'(N_REQ - 1);
            lock    <= 1'b0;
            lock_id <= '0;
        end else begin
            lock    <= div_in_valid && !div_in_ready;
            lock_id <= grant;
            if (hs) rr_ptr <= grant;
        end
    end

    dc_ipu_div_arb_tag_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .CW    (CW)
    ) u_tag_fifo (
        .clk   (clk),
        .reset (reset),
        .clr   (clr),
        .push  (hs),
        .din   (push_tag),
        .pop   (pop),
        .head  (head_tag),
        .empty (empty),
        .full  (full),
        .count (count)
    );

    // A divider result with nothing outstanding is a divider protocol error.
    assert property (@(posedge clk) disable iff (flush) !(div_out_valid && empty));
    assert property (@(posedge clk) disable iff (flush) !(hs && full));

endmodule

// File: tb/tb_dc_ipu_divider_arbiter.sv
// tb_dc_ipu_divider_arbiter: directed bench with an elastic divider model and in-order scoreboard.
module tb_dc_ipu_divider_arbiter;

    localparam int N   = 3;
    localparam int AW  = 16;
    localparam int BW  = 8;
    localparam int MO  = 18;
    localparam int LAT = AW;

    logic            clk = 1'b0;
    logic            reset;
    logic            clr;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N*AW-1:0] req_a;
    logic [N*BW-1:0] req_b;
    logic [N-1:0]    resp_valid;
    logic [N-1:0]    resp_ready;
    logic [AW-1:0]   resp_q;
    logic [BW-1:0]   resp_r;
    logic            resp_dz;
    logic            div_clr;
    logic            div_in_valid;
    logic            div_in_ready;
    logic [AW-1:0]   div_a;
    logic [BW-1:0]   div_b;
    logic            div_out_valid;
    logic            div_out_ready;
    logic [AW-1:0]   div_q;
    logic [BW-1:0]   div_r;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dc_ipu_divider_arbiter #(
        .N_REQ(N), .A_WIDTH(AW), .B_WIDTH(BW), .MAX_OUTSTANDING(MO)
    ) dut (
        .clk(clk), .reset(reset), .clr(clr),
        .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_q(resp_q), .resp_r(resp_r), .resp_dz(resp_dz),
        .div_clr(div_clr), .div_in_valid(div_in_valid), .div_in_ready(div_in_ready),
        .div_a(div_a), .div_b(div_b),
        .div_out_valid(div_out_valid), .div_out_ready(div_out_ready),
        .div_q(div_q), .div_r(div_r)
    );

    function automatic logic [AW-1:0] q_of(input logic [AW-1:0] a, input logic [BW-1:0] b);
        return (b == 0) ? '1 : a / AW'(b);
    endfunction

    function automatic logic [BW-1:0] r_of(input logic [AW-1:0] a, input logic [BW-1:0] b);
        return (b == 0) ? a[BW-1:0] : BW'(a % AW'(b));
    endfunction

    // Divider model: fixed LAT-cycle latency, results queue at the output while stalled.
    typedef struct { logic [AW-1:0] a; logic [BW-1:0] b; int t; } dop_t;
    dop_t          pipe[$];
    int            now = 0;
    logic          hold_in = 1'b0;
    logic          m_valid = 1'b0;
    logic [AW-1:0] m_q = '0;
    logic [BW-1:0] m_r = '0;
    int            m_occ = 0;

    assign div_in_ready  = !hold_in && (m_occ < 24);
    assign div_out_valid = m_valid;
    assign div_q         = m_q;
    assign div_r         = m_r;

    always @(posedge clk) begin
        dop_t d;
        now++;
        if (div_clr) pipe.delete();
        else begin
            if (div_out_valid && div_out_ready) void'(pipe.pop_front());
            if (div_in_valid && div_in_ready) begin
                d.a = div_a; d.b = div_b; d.t = now;
                pipe.push_back(d);
            end
        end
        m_occ <= pipe.size();
        if (pipe.size() > 0) begin
            m_valid <= (now - pipe[0].t) >= LAT;
            m_q     <= q_of(pipe[0].a, pipe[0].b);
            m_r     <= r_of(pipe[0].a, pipe[0].b);
        end else m_valid <= 1'b0;
    end

    // Requesters and scoreboard.
    typedef struct { int id; logic [AW-1:0] q; logic [BW-1:0] r; logic dz; } sb_t;
    sb_t           sb[$];
    int            glog[$];
    int            rem [N];
    logic [AW-1:0] ra [N];
    logic [BW-1:0] rb [N];
    logic [AW-1:0] step [N];
    int            last_grant;
    int            last_resp;
    int            n_acc = 0;
    int            n_resp = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive();
        for (int k = 0; k < N; k++) begin
            req_valid[k]        = rem[k] > 0;
            req_a[k*AW +: AW]   = ra[k];
            req_b[k*BW +: BW]   = rb[k];
        end
    endtask

    task automatic peek();
        drive();
        #1;
    endtask

    task automatic set_req(input int k, input int cnt, input logic [AW-1:0] a,
                           input logic [BW-1:0] b, input logic [AW-1:0] s);
        rem[k] = cnt; ra[k] = a; rb[k] = b; step[k] = s;
    endtask

    // Observes the handshakes of the coming posedge, then advances to the next negedge.
    task automatic tick();
        logic [N-1:0] acc;
        sb_t          e;
        drive();
        #1;
        acc        = req_ready;
        last_grant = -1;
        last_resp  = 0;
        for (int k = 0; k < N; k++) begin
            if (acc[k]) begin
                e.id = k;
                e.q  = q_of(ra[k], rb[k]);
                e.r  = r_of(ra[k], rb[k]);
`ifdef DC_IPU_DIV_ARB_DZ_FLAG_EN
                e.dz = (rb[k] == 0);
`else
                e.dz = 1'b0;
`endif
                sb.push_back(e);
                glog.push_back(k);
                last_grant = k;
                n_acc++;
            end
        end
        if ((resp_valid & resp_ready) != '0) begin
            last_resp = 1;
            n_resp++;
            if (sb.size() == 0) chk("resp_unexpected", 32'(resp_valid), 0);
            else begin
                e = sb.pop_front();
                chk("resp_owner", 32'(resp_valid), 32'(1) << e.id);
                chk("resp_q", 32'(resp_q), 32'(e.q));
                chk("resp_r", 32'(resp_r), 32'(e.r));
                chk("resp_dz", 32'(resp_dz), 32'(e.dz));
            end
        end
        @(negedge clk);
        for (int k = 0; k < N; k++) begin
            if (acc[k]) begin
                rem[k]--;
                ra[k] += step[k];
            end
        end
        drive();
    endtask

    task automatic wait_resp(output int n);
        n = 0;
        #1;
        while (resp_valid == '0 && n < 100) begin
            tick();
            #1;
            n++;
        end
    endtask

    function automatic int pending();
        int s = sb.size();
        for (int k = 0; k < N; k++) s += rem[k];
        return s;
    endfunction

    task automatic drain();
        int n = 0;
        while (pending() > 0 && n < 300) begin
            tick();
            n++;
        end
        chk("drain_left", pending(), 0);
    endtask

    initial begin
        int lat;
        int a0;
        int r0;
        reset = 1'b1; clr = 1'b0; resp_ready = '0;
        for (int k = 0; k < N; k++) set_req(k, 1, AW'(k + 10), 8'd3, '0);
        @(negedge clk);
        peek();
        chk("rst_div_clr", 32'(div_clr), 1);
        chk("rst_req_ready", 32'(req_ready), 0);
        chk("rst_in_valid", 32'(div_in_valid), 0);
        chk("rst_resp_valid", 32'(resp_valid), 0);
        tick();
        for (int k = 0; k < N; k++) rem[k] = 0;
        reset = 1'b0;
        peek();
        chk("idle_div_clr", 32'(div_clr), 0);
        chk("idle_in_valid", 32'(div_in_valid), 0);
        chk("idle_out_ready", 32'(div_out_ready), 1);

        // Single op: 1000 / 7 = 142 r 6.
        resp_ready = 3'b111;
        set_req(1, 1, 16'd1000, 8'd7, '0);
        peek();
        chk("one_in_valid", 32'(div_in_valid), 1);
        chk("one_req_ready", 32'(req_ready), 32'b010);
        chk("one_div_a", 32'(div_a), 1000);
        chk("one_div_b", 32'(div_b), 7);
        tick();
        chk("one_grant", last_grant, 1);
        wait_resp(lat);
        chk("one_latency", lat, LAT);
        chk("one_resp_valid", 32'(resp_valid), 32'b010);
        chk("one_q", 32'(resp_q), 142);
        chk("one_r", 32'(resp_r), 6);
        tick();
        peek();
        chk("one_empty_ready", 32'(div_out_ready), 1);
        chk("one_resp_idle", 32'(resp_valid), 0);

        // Clear restores rr_ptr, then a continuous stream from all three.
        clr = 1'b1;
        peek();
        chk("clr_div_clr", 32'(div_clr), 1);
        tick();
        clr = 1'b0;
        for (int k = 0; k < N; k++) set_req(k, 4, AW'(k * 100 + 1), 8'd3, 16'd7);
        glog.delete();
        drain();
        chk("rr_grants", glog.size(), 12);
        for (int i = 0; i < glog.size() && i < 12; i++) chk("rr_order", glog[i], i % 3);

        // Owner of the head result stalls: whole output frozen until released.
        resp_ready = 3'b110;
        set_req(0, 1, 16'd5000, 8'd13, '0);
        set_req(2, 1, 16'd4321, 8'd10, '0);
        tick();
        chk("stall_grant0", last_grant, 0);
        tick();
        chk("stall_grant2", last_grant, 2);
        wait_resp(lat);
        chk("stall_head", 32'(resp_valid), 32'b001);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("stall_out_ready", 32'(div_out_ready), 0);
        end
        chk("stall_hold_valid", 32'(resp_valid), 32'b001);
        chk("stall_hold_q", 32'(resp_q), 384);
        chk("stall_hold_r", 32'(resp_r), 8);
        resp_ready = 3'b111;
        tick();
        chk("stall_release", last_resp, 1);
        drain();

        // Grant lock: req 2 offered while divider not ready, req 0 then rises.
        hold_in = 1'b1;
        set_req(2, 1, 16'd500, 8'd9, '0);
        peek();
        chk("lock_in_valid", 32'(div_in_valid), 1);
        chk("lock_div_a0", 32'(div_a), 500);
        chk("lock_ready0", 32'(req_ready), 0);
        tick();
        set_req(0, 1, 16'd77, 8'd5, '0);
        repeat (3) tick();
        peek();
        chk("lock_div_a", 32'(div_a), 500);
        chk("lock_div_b", 32'(div_b), 9);
        chk("lock_ready", 32'(req_ready), 0);
        hold_in = 1'b0;
        tick();
        chk("lock_grant2", last_grant, 2);
        tick();
        chk("lock_grant0", last_grant, 0);
        drain();

        // Fill to the credit limit with all results blocked.
        resp_ready = '0;
        set_req(1, MO + 5, 16'd1000, 8'd7, 16'd3);
        a0 = n_acc;
        repeat (30) tick();
        chk("fill_accepted", n_acc - a0, MO);
        peek();
        chk("fill_in_valid", 32'(div_in_valid), 0);
        chk("fill_req_ready", 32'(req_ready), 0);
        resp_ready = 3'b010;
        a0 = n_acc;
        r0 = n_resp;
        tick();
        chk("fill_t1_grant", last_grant, -1);
        chk("fill_t1_resp", last_resp, 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("fill_both_grant", last_grant, 1);
            chk("fill_both_resp", last_resp, 1);
        end
        resp_ready = '0;
        tick();
        chk("fill_refill", last_grant, 1);
        tick();
        chk("fill_full_again", last_grant, -1);
        chk("fill_net_acc", n_acc - a0, 4);
        chk("fill_net_resp", n_resp - r0, 4);
        resp_ready = 3'b111;
        drain();

        // Clear with five ops in flight, then a fresh op.
        set_req(2, 5, 16'd2000, 8'd9, 16'd11);
        a0 = n_acc;
        r0 = n_resp;
        repeat (5) tick();
        chk("clr_inflight", n_acc - a0, 5);
        chk("clr_no_resp", n_resp - r0, 0);
        clr = 1'b1;
        set_req(0, 1, 16'd255, 8'd16, '0);
        peek();
        chk("clr_div_clr2", 32'(div_clr), 1);
        chk("clr_req_ready", 32'(req_ready), 0);
        chk("clr_in_valid", 32'(div_in_valid), 0);
        chk("clr_resp_valid", 32'(resp_valid), 0);
        tick();
        clr = 1'b0;
        sb.delete();
        resp_ready = '0;
        peek();
        chk("clr_fifo_empty", 32'(div_out_ready), 1);
        resp_ready = 3'b111;
        tick();
        chk("post_grant", last_grant, 0);
        wait_resp(lat);
        chk("post_latency", lat, LAT);
        chk("post_valid", 32'(resp_valid), 32'b001);
        chk("post_q", 32'(resp_q), 15);
        chk("post_r", 32'(resp_r), 15);
        chk("post_dz", 32'(resp_dz), 0);
        tick();
        drain();

`ifdef DC_IPU_DIV_ARB_DZ_FLAG_EN
        set_req(1, 1, 16'd300, 8'd0, '0);
        tick();
        wait_resp(lat);
        chk("dz_valid", 32'(resp_valid), 32'b010);
        chk("dz_flag", 32'(resp_dz), 1);
        tick();
        peek();
        chk("dz_idle", 32'(resp_dz), 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
